// File: rtl/fft_frame_arbiter_if.sv
// Signal bundle between fft_frame_arbiter, its two sample sources, and the SDF FFT core.
// master = arbiter side, slave = sources/FFT side.
interface fft_frame_arbiter_if #(
  parameter int DATA_WIDTH = 18
);
  logic                         req0;
  logic                         req1;
  logic                         grant0;
  logic                         grant1;
  logic                         src0_valid;
  logic                         src1_valid;
  logic signed [DATA_WIDTH-1:0] src0_r;
  logic signed [DATA_WIDTH-1:0] src0_i;
  logic signed [DATA_WIDTH-1:0] src1_r;
  logic signed [DATA_WIDTH-1:0] src1_i;
  logic                         start_FFT;
  logic signed [DATA_WIDTH-1:0] fft_in_r;
  logic signed [DATA_WIDTH-1:0] fft_in_i;
  logic signed [DATA_WIDTH-1:0] fft_out_r;
  logic signed [DATA_WIDTH-1:0] fft_out_i;
  logic                         data_valid_FFT;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_r;
  logic signed [DATA_WIDTH-1:0] out_i;
  logic                         out_chan;
  logic                         out_last;
  logic                         underrun;
  logic                         tag_err;

  modport master (
    input  req0, req1, src0_valid, src1_valid, src0_r, src0_i, src1_r, src1_i,
    input  fft_out_r, fft_out_i, data_valid_FFT,
    output grant0, grant1, start_FFT, fft_in_r, fft_in_i,
    output out_valid, out_r, out_i, out_chan, out_last, underrun, tag_err
  );

  modport slave (
    output req0, req1, src0_valid, src1_valid, src0_r, src0_i, src1_r, src1_i,
    output fft_out_r, fft_out_i, data_valid_FFT,
    input  grant0, grant1, start_FFT, fft_in_r, fft_in_i,
    input  out_valid, out_r, out_i, out_chan, out_last, underrun, tag_err
  );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Frame arbiter sharing one SDF FFT between two sources; tags frames and re-attaches the tag at the output.
// Define FFT_ARB_FIXED_PRIO_EN for fixed priority (req0 first) instead of round-robin.
module fft_frame_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int NFFT       = 64,
  parameter int TAG_DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  fft_frame_arbiter_if.master bus
);

  localparam int CW = $clog2(NFFT);
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STREAM} state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic                         r_winner;
  logic [CW-1:0]                r_cnt;
  logic [CW-1:0]                r_ocnt;
  logic [AW:0]                  r_wptr;
  logic [AW:0]                  r_rptr;
  logic [TAG_DEPTH-1:0]         r_tags;
  logic signed [DATA_WIDTH-1:0] r_fft_r;
  logic signed [DATA_WIDTH-1:0] r_fft_i;
  logic                         r_start;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_r;
  logic signed [DATA_WIDTH-1:0] r_out_i;
  logic                         r_out_chan;
  logic                         r_out_last;
  logic                         r_underrun;
  logic                         r_tag_err;

  logic                         w_pick;
  logic                         w_any_req;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_wrap;
  logic                         w_launch;
  logic                         w_grant0;
  logic                         w_grant1;
  logic                         w_push;
  logic                         w_stream;
  logic                         w_pop;
  logic                         w_head;
  logic                         w_src_valid;
  logic signed [DATA_WIDTH-1:0] w_src_r;
  logic signed [DATA_WIDTH-1:0] w_src_i;

`ifdef FFT_ARB_FIXED_PRIO_EN
  assign w_pick = ~bus.req0;
`else
  logic r_last;

  assign w_pick = (bus.req0 && bus.req1) ? ~r_last : ~bus.req0;

  always_ff @(posedge clk) begin
    if (rst)         r_last <= 1'b1;
    else if (w_push) r_last <= r_winner;
  end
`endif

  assign w_any_req = bus.req0 | bus.req1;
  assign w_full    = (r_wptr - r_rptr) == (AW + 1)'(TAG_DEPTH);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_head    = r_tags[r_rptr[AW-1:0]];
  assign w_wrap    = (r_state == S_STREAM) && (r_cnt == CW'(NFFT - 1));
  // Arbitrating on the wrap cycle as well as in IDLE gives the NFFT+1 back-to-back frame period.
  assign w_launch  = w_any_req && !w_full && ((r_state == S_IDLE) || w_wrap);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_winner <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_launch) r_winner <= w_pick;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_launch) w_next = S_GRANT;
      S_GRANT:  w_next = S_STREAM;
      S_STREAM: if (w_wrap) w_next = w_launch ? S_GRANT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    w_push   = 1'b0;
    w_stream = 1'b0;
    case (r_state)
      S_GRANT: begin
        w_grant0 = ~r_winner;
        w_grant1 = r_winner;
        w_push   = 1'b1;
      end
      S_STREAM: w_stream = 1'b1;
      default: ;
    endcase
  end

  assign w_src_valid = r_winner ? bus.src1_valid : bus.src0_valid;
  assign w_src_r     = r_winner ? bus.src1_r : bus.src0_r;
  assign w_src_i     = r_winner ? bus.src1_i : bus.src0_i;

  // A tag is only consumed when it exists; an orphan frame end leaves the FIFO alone.
  assign w_pop = bus.data_valid_FFT && !w_empty && (r_ocnt == CW'(NFFT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_ocnt      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tags      <= '0;
      r_fft_r     <= '0;
      r_fft_i     <= '0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_chan  <= 1'b0;
      r_out_last  <= 1'b0;
      r_underrun  <= 1'b0;
      r_tag_err   <= 1'b0;
    end else begin
      if (w_push)        r_cnt <= '0;
      else if (w_stream) r_cnt <= r_cnt + 1'b1;

      r_fft_r <= (w_stream && w_src_valid) ? w_src_r : '0;
      r_fft_i <= (w_stream && w_src_valid) ? w_src_i : '0;
      r_start <= w_stream && (r_cnt == '0);
      if (w_stream && !w_src_valid) r_underrun <= 1'b1;

      if (w_push) begin
        r_tags[r_wptr[AW-1:0]] <= r_winner;
        r_wptr                 <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;

      if (bus.data_valid_FFT) r_ocnt <= r_ocnt + 1'b1;
      r_out_valid <= bus.data_valid_FFT;
      r_out_r     <= bus.fft_out_r;
      r_out_i     <= bus.fft_out_i;
      r_out_chan  <= bus.data_valid_FFT && !w_empty && w_head;
      r_out_last  <= bus.data_valid_FFT && (r_ocnt == CW'(NFFT - 1));
      if (bus.data_valid_FFT && w_empty) r_tag_err <= 1'b1;
    end
  end

  assign bus.grant0    = w_grant0;
  assign bus.grant1    = w_grant1;
  assign bus.start_FFT = r_start;
  assign bus.fft_in_r  = r_fft_r;
  assign bus.fft_in_i  = r_fft_i;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_i     = r_out_i;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_last  = r_out_last;
  assign bus.underrun  = r_underrun;
  assign bus.tag_err   = r_tag_err;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: sources and a fixed-latency FFT are modelled here,
// expected values are hand-derived from the grant cycle T.
module tb_fft_frame_arbiter;
  localparam int DW   = 18;
  localparam int NFFT = 64;
  localparam int TD   = 4;
  localparam int LAT  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  fft_frame_arbiter #(.DATA_WIDTH(DW), .NFFT(NFFT), .TAG_DEPTH(TD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // request bookkeeping: a source requests while granted < want
  int want[2]    = '{0, 0};
  int granted[2] = '{0, 0};
  int base[2]    = '{1, 1000};
  int drop_at[2] = '{-1, -1};
  int left[2]    = '{0, 0};
  assign bus.req0 = granted[0] < want[0];
  assign bus.req1 = granted[1] < want[1];

  // sources: sample k is driven in cycle T+1+k after a grant in cycle T
  always @(negedge clk) begin
    logic v;
    logic signed [DW-1:0] d;
    for (int s = 0; s < 2; s++) begin
      v = 1'b0;
      d = '0;
      if (rst) left[s] = 0;
      else begin
        if (left[s] > 0) begin
          v = (NFFT - left[s]) != drop_at[s];
          d = DW'(base[s] + NFFT - left[s]);
          left[s]--;
        end
        if ((s == 0) ? bus.grant0 : bus.grant1) begin
          left[s] = NFFT;
          granted[s]++;
        end
      end
      if (s == 0) begin
        bus.src0_valid = v; bus.src0_r = d; bus.src0_i = -d;
      end else begin
        bus.src1_valid = v; bus.src1_r = d; bus.src1_i = -d;
      end
    end
  end

  // FFT model: NFFT valid samples (values 0..NFFT-1) starting LAT cycles after start_FFT
  bit fft_en = 1'b1;
  logic man_valid = 1'b0;
  logic signed [DW-1:0] man_r = '0;
  logic m_valid = 1'b0;
  logic signed [DW-1:0] m_r = '0;
  logic signed [DW-1:0] m_i = '0;
  int fq[$];
  int burst = 0;
  assign bus.data_valid_FFT = fft_en ? m_valid : man_valid;
  assign bus.fft_out_r      = fft_en ? m_r : man_r;
  assign bus.fft_out_i      = fft_en ? m_i : '0;

  always @(negedge clk) begin
    if (rst) begin
      fq.delete(); burst = 0; m_valid = 1'b0; m_r = '0; m_i = '0;
    end else begin
      if (bus.start_FFT) fq.push_back(cyc + LAT);
      if (burst == 0 && fq.size() > 0 && fq[0] <= cyc) begin
        void'(fq.pop_front());
        burst = NFFT;
      end
      if (burst > 0) begin
        m_valid = 1'b1; m_r = DW'(NFFT - burst); m_i = -m_r; burst--;
      end else begin
        m_valid = 1'b0; m_r = '0; m_i = '0;
      end
    end
  end

  // monitor
  int g_t[$];
  int g_id[$];
  int last_chan[$];
  int last_pos[$];
  int last_r[$];
  int ov_cnt = 0;
  int first_ov = -1;
  always @(negedge clk) begin
    if (rst) begin
      g_t.delete(); g_id.delete(); last_chan.delete(); last_pos.delete(); last_r.delete();
      ov_cnt = 0; first_ov = -1;
    end else begin
      if (bus.grant0) begin g_t.push_back(cyc); g_id.push_back(0); end
      if (bus.grant1) begin g_t.push_back(cyc); g_id.push_back(1); end
      if (bus.out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
        if (bus.out_last) begin
          last_chan.push_back(int'(bus.out_chan));
          last_pos.push_back(ov_cnt);
          last_r.push_back(int'(bus.out_r));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    want[0] = granted[0];
    want[1] = granted[1];
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int n0, input int n1);
    want[0] = granted[0] + n0;
    want[1] = granted[1] + n1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (g_t.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("grant_count", g_t.size(), n);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t;
    int exp_id[4];
    int p;

    // reset state
    do_reset();
    check("rst_grant0", bus.grant0, 0);
    check("rst_grant1", bus.grant1, 0);
    check("rst_start", bus.start_FFT, 0);
    check("rst_fft_in_r", bus.fft_in_r, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_chan", bus.out_chan, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_tag_err", bus.tag_err, 0);

    // single source ramp 1..NFFT
    set_req(1, 0);
    wait_grants(1, 20);
    t = g_t.size() > 0 ? g_t[0] : cyc;
    if (g_id.size() > 0) check("single_id", g_id[0], 0);
    goto(t + 1);
    check("single_start_early", bus.start_FFT, 0);
    for (int k = 0; k < NFFT; k++) begin
      goto(t + 2 + k);
      if (k == 0) check("single_start", bus.start_FFT, 1);
      if (k == 1) check("single_start_pulse", bus.start_FFT, 0);
      check($sformatf("single_in_r[%0d]", k), bus.fft_in_r, k + 1);
      check($sformatf("single_in_i[%0d]", k), bus.fft_in_i, -(k + 1));
    end
    goto(t + NFFT + 2);
    check("single_in_after", bus.fft_in_r, 0);
    check("single_underrun", bus.underrun, 0);

    // contention, 4 frames
    do_reset();
    set_req(4, 4);
    wait_grants(4, 400);
`ifdef FFT_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    if (g_t.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cont_id[%0d]", i), g_id[i], exp_id[i]);
        check($sformatf("cont_t[%0d]", i), g_t[i] - g_t[0], (NFFT + 1) * i);
      end
    end

    // underrun on source 1 at sample 10
    do_reset();
    drop_at[1] = 10;
    set_req(0, 1);
    wait_grants(1, 20);
    t = g_t.size() > 0 ? g_t[0] : cyc;
    if (g_id.size() > 0) check("under_id", g_id[0], 1);
    goto(t + 11);
    check("under_before", bus.underrun, 0);
    check("under_in_s9", bus.fft_in_r, 1009);
    goto(t + 12);
    check("under_set", bus.underrun, 1);
    check("under_in_s10", bus.fft_in_r, 0);
    goto(t + 13);
    check("under_in_s11", bus.fft_in_r, 1011);
    goto(t + 80);
    check("under_sticky", bus.underrun, 1);
    drop_at[1] = -1;
    do_reset();
    check("under_cleared", bus.underrun, 0);

    // tag tracking with LAT-cycle FFT, frames 0,1,1
    set_req(1, 2);
    wait_grants(3, 300);
    t = g_t.size() > 0 ? g_t[0] : cyc;
    if (g_id.size() >= 3) begin
      check("tag_gid0", g_id[0], 0);
      check("tag_gid1", g_id[1], 1);
      check("tag_gid2", g_id[2], 1);
    end
    p = 0;
    while (last_chan.size() < 3 && p < 800) begin
      @(negedge clk);
      p++;
    end
    check("tag_frames", last_chan.size(), 3);
    check("tag_first_out", first_ov, t + 3 + LAT);
    exp_id = '{0, 1, 1, 0};
    if (last_chan.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("tag_chan[%0d]", i), last_chan[i], exp_id[i]);
        check($sformatf("tag_lastpos[%0d]", i), last_pos[i], NFFT * (i + 1));
        check($sformatf("tag_last_r[%0d]", i), last_r[i], NFFT - 1);
      end
    end
    check("tag_err_clear", bus.tag_err, 0);

    // back-pressure: tag FIFO full stalls the fifth grant
    fft_en = 1'b0;
    do_reset();
    set_req(5, 0);
    wait_grants(4, 400);
    t = g_t.size() > 0 ? g_t[g_t.size() - 1] : cyc;
    goto(t + NFFT + 150);
    check("bp_grants_stalled", g_t.size(), 4);
    check("bp_req_held", bus.req0, 1);
    for (int k = 0; k < NFFT; k++) begin
      @(negedge clk);
      man_valid = 1'b1;
      man_r = DW'(k);
    end
    @(negedge clk);
    man_valid = 1'b0;
    check("bp_out_last", bus.out_last, 1);
    check("bp_out_chan", bus.out_chan, 0);
    check("bp_no_grant_yet", bus.grant0, 0);
    @(negedge clk);
    check("bp_release", bus.grant0, 1);

    // tag error on empty FIFO
    do_reset();
    @(negedge clk);
    man_valid = 1'b1;
    man_r = DW'(5);
    check("terr_before", bus.tag_err, 0);
    @(negedge clk);
    man_valid = 1'b0;
    check("terr_set", bus.tag_err, 1);
    check("terr_valid", bus.out_valid, 1);
    check("terr_chan", bus.out_chan, 0);
    check("terr_out_r", bus.out_r, 5);
    @(negedge clk);
    check("terr_sticky", bus.tag_err, 1);

    // reset in the middle of a stream
    fft_en = 1'b1;
    do_reset();
    set_req(0, 1);
    wait_grants(1, 20);
    t = g_t.size() > 0 ? g_t[0] : cyc;
    goto(t + 31);
    check("mid_streaming", bus.fft_in_r, 1029);
    rst = 1'b1;
    @(negedge clk);
    check("mid_grant0", bus.grant0, 0);
    check("mid_grant1", bus.grant1, 0);
    check("mid_start", bus.start_FFT, 0);
    check("mid_in_r", bus.fft_in_r, 0);
    check("mid_in_i", bus.fft_in_i, 0);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_out_last", bus.out_last, 0);
    check("mid_underrun", bus.underrun, 0);
    check("mid_tag_err", bus.tag_err, 0);
    rst = 1'b0;
    set_req(1, 1);
    @(negedge clk);
    check("mid_next_grant0", bus.grant0, 1);
    check("mid_next_grant1", bus.grant1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
